// File: rtl/featuremap_pad_scheduler.sv
// ============================================================================
//  Module   : featuremap_pad_scheduler
//  Brief    : Streams a WIDTHxHEIGHT map from CH lock-step show-ahead FIFOs
//             as a (WIDTH+2)x(HEIGHT+2) raster with a one-pixel zero border.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module featuremap_pad_scheduler #(
  parameter  int DATA_WIDTH = 32,
  parameter  int CH         = 16,
  parameter  int WIDTH      = 56,
  parameter  int HEIGHT     = 56,
  localparam int RW         = $clog2(HEIGHT + 2),
  localparam int CW         = $clog2(WIDTH + 2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CH-1:0]            fifo_empty,
  input  logic [CH*DATA_WIDTH-1:0] fifo_data,
  output logic                     fifo_rdreq,
  output logic [CH*DATA_WIDTH-1:0] pix_data,
  output logic                     pix_valid,
  output logic                     busy,
  output logic                     done,
  output logic [RW-1:0]            row_cnt,
  output logic [CW-1:0]            col_cnt
);

  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [RW-1:0]            row_q, row_d;
  logic [CW-1:0]            col_q, col_d;
  logic [CH*DATA_WIDTH-1:0] pix_data_q, pix_data_d;
  logic                     pix_valid_q, pix_valid_d;
  logic                     done_q, done_d;

  logic all_ready;
  logic interior;
  logic advance;

  assign all_ready = ~|fifo_empty;
  // Border positions are row/col 0 and the last row/col of the padded grid.
  assign interior  = (row_q != '0) && (row_q != ROW_LAST) &&
                     (col_q != '0) && (col_q != COL_LAST);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = 1'b0;
    done_d      = 1'b0;
    advance     = 1'b0;
    fifo_rdreq  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (!interior) begin
          pix_data_d  = '0;
          pix_valid_d = 1'b1;
          advance     = 1'b1;
        end else if (all_ready) begin
          fifo_rdreq  = 1'b1;
          pix_data_d  = fifo_data;
          pix_valid_d = 1'b1;
          advance     = 1'b1;
        end

        if (advance) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = S_DONE;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end

      // The last pixel is on the output during this state; done follows it.
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      done_q      <= done_d;
    end
  end

  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);
  assign row_cnt   = row_q;
  assign col_cnt   = col_q;

endmodule

`default_nettype wire

// File: tb/tb_featuremap_pad_scheduler.sv
// ============================================================================
//  Module   : tb_featuremap_pad_scheduler
//  Brief    : Scoreboard bench for featuremap_pad_scheduler on a 4x3 map.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_featuremap_pad_scheduler;

  localparam int DW   = 32;
  localparam int CH   = 16;
  localparam int W    = 4;
  localparam int H    = 3;
  localparam int W2   = W + 2;
  localparam int H2   = H + 2;
  localparam int NPIX = W2 * H2;
  localparam int NINT = W * H;
  localparam int VW   = CH * DW;
  localparam int RW   = $clog2(H2);
  localparam int CW   = $clog2(W2);

  logic          clk;
  logic          rst;
  logic          start;
  logic [CH-1:0] fifo_empty;
  logic [VW-1:0] fifo_data;
  logic          fifo_rdreq;
  logic [VW-1:0] pix_data;
  logic          pix_valid;
  logic          busy;
  logic          done;
  logic [RW-1:0] row_cnt;
  logic [CW-1:0] col_cnt;

  featuremap_pad_scheduler #(
    .DATA_WIDTH(DW),
    .CH        (CH),
    .WIDTH     (W),
    .HEIGHT    (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rdreq(fifo_rdreq),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .busy      (busy),
    .done      (done),
    .row_cnt   (row_cnt),
    .col_cnt   (col_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [VW-1:0] fq[$];     // lock-step FIFO contents, one entry per pixel
  logic [VW-1:0] exp_q[$];  // expected padded raster
  logic [CH-1:0] force_empty = '0;
  int unsigned   rand_pct    = 0;
  logic          rd_s        = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame of interior samples plus its padded reference raster.
  task automatic load_frame(input bit pattern);
    logic [VW-1:0] vals[NINT];
    logic [VW-1:0] v;
    int idx;
    for (int i = 0; i < NINT; i++) begin
      for (int k = 0; k < CH; k++) begin
        v[k*DW +: DW] = pattern ? DW'(k * 100 + i) : DW'($urandom);
      end
      vals[i] = v;
      fq.push_back(v);
    end
    idx = 0;
    for (int r = 0; r < H2; r++) begin
      for (int c = 0; c < W2; c++) begin
        if (r >= 1 && r <= H && c >= 1 && c <= W) begin
          exp_q.push_back(vals[idx]);
          idx++;
        end else begin
          exp_q.push_back('0);
        end
      end
    end
  endtask

  // FIFO model: pop on the sampled strobe, then refresh flags and head.
  initial begin
    logic [CH-1:0] rnd;
    fifo_empty = '1;
    fifo_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_s && fq.size() > 0) fq.delete(0);
      #2;
      for (int k = 0; k < CH; k++) rnd[k] = ($urandom_range(99) < rand_pct);
      fifo_empty = force_empty | rnd | {CH{fq.size() == 0}};
      fifo_data  = (fq.size() > 0) ? fq[0] : '0;
      @(negedge clk);
      rd_s = fifo_rdreq;
    end
  end

  // Monitor: pixel scoreboard, pop legality and end-of-frame accounting.
  initial begin
    int pix_cnt = 0;
    int pop_cnt = 0;
    logic prev_valid = 1'b0;
    logic prev_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pix_cnt = 0; pop_cnt = 0; prev_valid = 1'b0; prev_done = 1'b0;
      end else begin
        if (fifo_rdreq) begin
          pop_cnt++;
          check_val("pop_needs_all_ready", VW'(|fifo_empty), VW'(0));
        end
        if (pix_valid) begin
          pix_cnt++;
          if (exp_q.size() == 0) begin
            check_val("pix_unexpected", VW'(pix_cnt), VW'(0));
          end else begin
            check_val("pix_data", pix_data, exp_q.pop_front());
          end
        end
        if (done) begin
          check_val("done_busy_low", VW'(busy), VW'(0));
          check_val("done_after_last_pix", VW'(prev_valid), VW'(1));
          check_val("done_single_pulse", VW'(prev_done), VW'(0));
          check_val("frame_pix_count", VW'(pix_cnt), VW'(NPIX));
          check_val("frame_pop_count", VW'(pop_cnt), VW'(NINT));
          check_val("frame_exp_drained", VW'(exp_q.size()), VW'(0));
          pix_cnt = 0;
          pop_cnt = 0;
        end
        prev_valid = pix_valid;
        prev_done  = done;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Returns with the start-sampling edge T behind us, at T+2.
  task automatic pulse_start();
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    #4;
    check_val("busy_after_start", VW'(busy), VW'(1));
    check_val("no_pix_before_T2", VW'(pix_valid), VW'(0));
  endtask

  // n counts edges after T; the DUT sits at padded position n while unstalled.
  task automatic run_frame(input logic [CH-1:0] f_mask, input int f_from, input int f_to,
                           input int hold_from, input int hold_len, input int mid_start,
                           input int reset_at, input int exp_lat);
    bit got_done = 1'b0;
    int hold_pos = hold_from;
    for (int n = 1; n < 2000 && !got_done; n++) begin
      cyc();
      force_empty = (n >= f_from && n < f_to) ? f_mask : '0;
      start       = (n == mid_start);
      if (n == reset_at) begin
        rst = 1'b0;
        #1;
        check_val("rst_pix_valid", VW'(pix_valid), VW'(0));
        check_val("rst_pix_data", pix_data, VW'(0));
        check_val("rst_busy", VW'(busy), VW'(0));
        check_val("rst_done", VW'(done), VW'(0));
        check_val("rst_rdreq", VW'(fifo_rdreq), VW'(0));
        check_val("rst_counters", VW'({row_cnt, col_cnt}), VW'(0));
        return;
      end
      #4;
      if (hold_len > 0 && n <= hold_from) begin
        check_val("border_streams", VW'(pix_valid), VW'(1));
      end
      if (hold_len > 0 && n >= hold_from && n < hold_from + hold_len) begin
        check_val("stall_rdreq", VW'(fifo_rdreq), VW'(0));
        check_val("stall_row", VW'(row_cnt), VW'(hold_pos / W2));
        check_val("stall_col", VW'(col_cnt), VW'(hold_pos % W2));
      end
      if (hold_len > 0 && n > hold_from && n <= hold_from + hold_len) begin
        check_val("stall_no_valid", VW'(pix_valid), VW'(0));
      end
      if (done) begin
        got_done = 1'b1;
        if (exp_lat >= 0) check_val("done_latency", VW'(n), VW'(exp_lat));
      end
    end
    force_empty = '0;
    start       = 1'b0;
    if (!got_done) check_val("done_timeout", VW'(0), VW'(1));
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) cyc();
    #4;
    check_val("reset_pix_valid", VW'(pix_valid), VW'(0));
    check_val("reset_pix_data", pix_data, VW'(0));
    check_val("reset_busy_done", VW'({busy, done, fifo_rdreq}), VW'(0));
    check_val("reset_counters", VW'({row_cnt, col_cnt}), VW'(0));
    cyc();
    rst = 1'b1;
    cyc();

    // Plain patterned frame.
    load_frame(1'b1);
    pulse_start();
    run_frame('0, 0, 0, 0, 0, -1, -1, NPIX + 1);

    // Channel 5 empty for 4 cycles at the third interior pixel (1,3).
    load_frame(1'b1);
    pulse_start();
    run_frame(CH'(1) << 5, W2 + 3, W2 + 7, W2 + 3, 4, -1, -1, NPIX + 5);

    // All FIFOs empty until well past (1,1): top border still streams.
    load_frame(1'b1);
    force_empty = '1;
    pulse_start();
    run_frame('1, 0, 10, W2 + 1, 3, -1, -1, NPIX + 4);

    // Mid-frame start ignored, then a back-to-back frame.
    load_frame(1'b1);
    pulse_start();
    run_frame('0, 0, 0, 0, 0, 10, -1, NPIX + 1);
    load_frame(1'b1);
    pulse_start();
    run_frame('0, 0, 0, 0, 0, -1, -1, NPIX + 1);

    // Reset at pixel 15, then a clean restart from (0,0).
    load_frame(1'b1);
    pulse_start();
    run_frame('0, 0, 0, 0, 0, -1, 16, -1);
    fq.delete();
    exp_q.delete();
    cyc();
    cyc();
    rst = 1'b1;
    load_frame(1'b1);
    pulse_start();
    run_frame('0, 0, 0, 0, 0, -1, -1, NPIX + 1);

    // Random data with random per-channel empties and stray starts.
    rand_pct = 25;
    for (int f = 0; f < 5; f++) begin
      load_frame(1'b0);
      pulse_start();
      run_frame('0, 0, 0, 0, 0, int'($urandom_range(5, 25)), -1, -1);
    end
    rand_pct = 0;

    repeat (3) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish by %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/featuremap_pad_scheduler.md
# featuremap_pad_scheduler

Sequencing controller for one 16-channel convolution feature-map block. It reads a WIDTH×HEIGHT unpadded map from 16 per-channel input FIFOs in lock-step and inserts a one-pixel zero border around it. The result is a raster stream of (WIDTH+2)×(HEIGHT+2) pixels that drives the 16 conv2D line-buffer instances, which are configured for row length WIDTH+2. It is the only source of the shared read strobe for the channel FIFOs.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one channel sample (IEEE-754 single)
- CH, 16, number of input channels
- WIDTH, 56, unpadded map width
- HEIGHT, 56, unpadded map height

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse that begins a frame; ignored while busy=1
- fifo_empty  in  CH  per-channel FIFO empty flags
- fifo_data  in  CH*DATA_WIDTH  show-ahead FIFO heads; channel k is at [k*DATA_WIDTH +: DATA_WIDTH]
- fifo_rdreq  out  1  shared pop strobe to all CH FIFOs (combinational)
- pix_data  out  CH*DATA_WIDTH  padded pixel for all channels (registered)
- pix_valid  out  1  pix_data valid this cycle; drives conv2D valid_in
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last padded pixel is issued
- row_cnt  out  clog2(HEIGHT+2)  current padded row r
- col_cnt  out  clog2(WIDTH+2)  current padded column c

## Operation
- The FIFOs are show-ahead: the head is valid while empty=0, and asserting rdreq pops it at the clock edge.
- FSM states:
  - IDLE: counters at 0, busy=0. On start, go to RUN.
  - RUN: walk r over 0..HEIGHT+1 (outer) and c over 0..WIDTH+1 (inner).
  - DONE: assert done for one cycle, then go to IDLE.
- Position (r,c) is interior iff 1≤r≤HEIGHT and 1≤c≤WIDTH. Every other position is padding.
- all_ready = ~|fifo_empty.
- RUN, padding position:
  - pix_data <= 0 and pix_valid <= 1, with no pop.
  - Advance the counters regardless of the empty flags.
- RUN, interior position with all_ready=1:
  - fifo_rdreq=1.
  - pix_data <= fifo_data and pix_valid <= 1.
  - Advance the counters.
- RUN, interior position with all_ready=0 (stall):
  - fifo_rdreq=0 and pix_valid <= 0.
  - Counters and pix_data hold.
- Counter advance: c increments. When c=WIDTH+1, c wraps to 0 and r increments. Advancing from (HEIGHT+1, WIDTH+1) goes to DONE, with r and c cleared to 0.
- fifo_rdreq = (state==RUN) & interior & all_ready. It is never asserted outside RUN.
- A partial empty (some channels empty) stalls every channel; no channel is ever popped alone.
- start during RUN or DONE is ignored.
- Reset mid-frame: all state and outputs return to reset values immediately. The contents of the FIFOs are not this block's concern.
- A frame makes exactly WIDTH×HEIGHT pops and issues exactly (WIDTH+2)×(HEIGHT+2) valid pixels.

## Timing
- Reset values: fifo_rdreq=0, pix_data=0, pix_valid=0, busy=0, done=0, row_cnt=0, col_cnt=0, state=IDLE.
- start sampled at edge T:
  - busy=1 from T+1.
  - Padded pixel (0,0) is presented with pix_valid=1 in cycle T+2.
- Registered data latency is 1 cycle: the pixel selected in cycle n appears on pix_data in cycle n+1.
- Frame length with no stalls: (WIDTH+2)×(HEIGHT+2) consecutive pix_valid cycles. For the default parameters this is 3364 cycles with 3136 pops.
- Each stall cycle adds exactly one cycle to the frame.
- done:
  - Asserted in the cycle after the last pixel's pix_valid.
  - busy drops in the same cycle as done.
  - A start in the cycle after done begins a new frame.
- Top/bottom border rows and the left/right columns never stall, even if every FIFO is empty.

## Test plan
- WIDTH=4, HEIGHT=3, FIFOs preloaded with channel k, pixel i = k*100+i, then start:
  - 30 consecutive pix_valid cycles.
  - The first 7 pixels and the last 7 pixels are 0.
  - Pixel 7 = {k*100+0}.
  - 12 fifo_rdreq pulses, then done pulses once.
- Same setup, but channel 5 is empty during the 3rd interior pixel for 4 cycles:
  - fifo_rdreq=0 and pix_valid=0 for 4 cycles; row_cnt and col_cnt hold.
  - Frame length is 34 cycles, and the output data matches the unstalled run.
- All FIFOs empty until the counters reach (1,1):
  - The first 7 padding pixels still stream without stall.
  - The stall starts at (1,1).
- start pulsed mid-frame → ignored. start one cycle after done → a second identical 30-pixel frame.
- rst driven low at pixel 15 → all outputs 0 immediately. A start after reset release → the frame restarts at (0,0).
- Default parameters, FIFOs never empty → 3364 pix_valid cycles, 3136 pops, done at cycle start+3366.
